// File: rtl/boot_loader.sv
// Boot loader: parses a MAGIC + 16-bit word-count byte image, writes it to BRAM as LE words,
// then releases the CPU and hands over the bus. Define BOOT_LOADER_RELOAD_EN to allow re-loading from RUN.
module boot_loader #(
    parameter logic [31:0] LOAD_BASE = 32'h0000_0000,
    parameter int unsigned MEM_WORDS = 256,
    parameter logic [7:0]  MAGIC     = 8'hA5
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        rx_valid,
    input  logic [7:0]  rx_data,
    output logic        rx_ready,
    output logic        cpu_reset_n,
    input  logic        cpu_mem_valid,
    input  logic [31:0] cpu_mem_addr,
    input  logic [31:0] cpu_mem_wdata,
    input  logic [3:0]  cpu_mem_wstrb,
    output logic        cpu_mem_ready,
    output logic [31:0] cpu_mem_rdata,
    output logic        mem_valid,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wstrb,
    input  logic        mem_ready,
    input  logic [31:0] mem_rdata,
    output logic        load_done,
    output logic        load_error
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEN0,
        S_LEN1,
        S_DATA,
        S_WRITE,
        S_RUN,
        S_ERROR
`ifdef BOOT_LOADER_RELOAD_EN
        , S_DRAIN
`endif
    } state_t;

    state_t      r_state;
    logic [15:0] r_index;
    logic [1:0]  r_byte_cnt;
    logic [15:0] r_length;
    logic [23:0] r_word;
    logic        r_rx_ready;
    logic        r_cpu_reset_n;
    logic        r_mem_valid;
    logic [31:0] r_mem_addr;
    logic [31:0] r_mem_wdata;
    logic [3:0]  r_mem_wstrb;
    logic        r_load_done;
    logic        r_load_error;

    logic        w_rx_fire;
    logic [15:0] w_len;
    logic        w_len_bad;
    logic        w_last;
    logic [31:0] w_word_addr;
    logic        w_cpu_bus;
    logic        w_cpu_run;

    assign w_rx_fire   = rx_valid && r_rx_ready;
    assign w_len       = {rx_data, r_length[7:0]};
    assign w_len_bad   = (w_len == 16'd0) || (32'(w_len) > MEM_WORDS);
    assign w_last      = (r_index == (r_length - 16'd1));
    assign w_word_addr = LOAD_BASE + {14'd0, r_index, 2'b00};
    assign w_cpu_run   = (r_state == S_RUN);
`ifdef BOOT_LOADER_RELOAD_EN
    assign w_cpu_bus   = w_cpu_run || (r_state == S_DRAIN);
`else
    assign w_cpu_bus   = w_cpu_run;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= S_IDLE;
            r_index       <= '0;
            r_byte_cnt    <= '0;
            r_length      <= '0;
            r_word        <= '0;
            r_rx_ready    <= 1'b1;
            r_cpu_reset_n <= 1'b0;
            r_mem_valid   <= 1'b0;
            r_mem_addr    <= '0;
            r_mem_wdata   <= '0;
            r_mem_wstrb   <= '0;
            r_load_done   <= 1'b0;
            r_load_error  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_rx_fire && rx_data == MAGIC)
                        r_state <= S_LEN0;
                end
                S_LEN0: begin
                    if (w_rx_fire) begin
                        r_length[7:0] <= rx_data;
                        r_state       <= S_LEN1;
                    end
                end
                S_LEN1: begin
                    if (w_rx_fire) begin
                        r_length[15:8] <= rx_data;
                        if (w_len_bad) begin
                            r_state      <= S_ERROR;
                            r_rx_ready   <= 1'b0;
                            r_load_error <= 1'b1;
                        end else begin
                            r_state    <= S_DATA;
                            r_index    <= '0;
                            r_byte_cnt <= '0;
                        end
                    end
                end
                S_DATA: begin
                    if (w_rx_fire) begin
                        r_byte_cnt <= r_byte_cnt + 2'd1;
                        case (r_byte_cnt)
                            2'd0: r_word[7:0]   <= rx_data;
                            2'd1: r_word[15:8]  <= rx_data;
                            2'd2: r_word[23:16] <= rx_data;
                            default: begin
                                // Fourth byte goes straight into the write word; no need to stage it.
                                r_state     <= S_WRITE;
                                r_rx_ready  <= 1'b0;
                                r_mem_valid <= 1'b1;
                                r_mem_addr  <= w_word_addr;
                                r_mem_wdata <= {rx_data, r_word};
                                r_mem_wstrb <= '1;
                            end
                        endcase
                    end
                end
                S_WRITE: begin
                    if (mem_ready) begin
                        r_mem_valid <= 1'b0;
                        r_mem_addr  <= '0;
                        r_mem_wdata <= '0;
                        r_mem_wstrb <= '0;
                        r_index     <= r_index + 16'd1;
                        if (w_last) begin
                            r_state       <= S_RUN;
                            r_cpu_reset_n <= 1'b1;
                            r_load_done   <= 1'b1;
`ifdef BOOT_LOADER_RELOAD_EN
                            r_rx_ready    <= 1'b1;
`else
                            r_rx_ready    <= 1'b0;
`endif
                        end else begin
                            r_state    <= S_DATA;
                            r_rx_ready <= 1'b1;
                        end
                    end
                end
`ifdef BOOT_LOADER_RELOAD_EN
                S_RUN: begin
                    if (w_rx_fire && rx_data == MAGIC) begin
                        r_state       <= S_DRAIN;
                        r_cpu_reset_n <= 1'b0;
                        r_load_done   <= 1'b0;
                        r_rx_ready    <= 1'b0;
                    end
                end
                S_DRAIN: begin
                    // Let any CPU access already on the bus finish before the loader reclaims it.
                    if (!cpu_mem_valid || mem_ready) begin
                        r_state    <= S_LEN0;
                        r_index    <= '0;
                        r_byte_cnt <= '0;
                        r_rx_ready <= 1'b1;
                    end
                end
`else
                S_RUN: begin
                end
`endif
                S_ERROR: begin
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign rx_ready      = r_rx_ready;
    assign cpu_reset_n   = r_cpu_reset_n;
    assign load_done     = r_load_done;
    assign load_error    = r_load_error;

    // Reset gates mem_valid combinationally so an in-flight write is withdrawn in the reset cycle.
    assign mem_valid     = !reset && (w_cpu_bus ? cpu_mem_valid : r_mem_valid);
    assign mem_addr      = w_cpu_bus ? cpu_mem_addr  : r_mem_addr;
    assign mem_wdata     = w_cpu_bus ? cpu_mem_wdata : r_mem_wdata;
    assign mem_wstrb     = w_cpu_bus ? cpu_mem_wstrb : r_mem_wstrb;

    assign cpu_mem_ready = w_cpu_run && mem_ready;
    assign cpu_mem_rdata = w_cpu_run ? mem_rdata : '0;

endmodule

// File: doc/boot_loader.md
Name: boot_loader

Overview:
- Sits between `cpu` and `bram_controller` on the PicoRV32 native memory bus.
- After reset it owns the memory bus and holds the CPU in reset.
- It receives a program image as a byte stream from an upstream UART receiver. It packs the bytes into little-endian 32-bit words and writes them to BRAM.
- When the image is complete it releases the CPU reset and hands the bus to the CPU. This replaces bench-driven program loading in hardware.

Parameters:
- LOAD_BASE, 32'h00000000, byte address of the first loaded word.
- MEM_WORDS, 256, maximum accepted image length in words.
- MAGIC, 8'hA5, start-of-image byte.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- rx_valid  in  1  upstream byte valid.
- rx_data  in  8  upstream byte.
- rx_ready  out  1  byte accepted when rx_valid && rx_ready on a rising clk edge.
- cpu_reset_n  out  1  drives cpu.reset_n.
- cpu_mem_valid  in  1  CPU memory request valid.
- cpu_mem_addr  in  32  CPU memory address.
- cpu_mem_wdata  in  32  CPU write data.
- cpu_mem_wstrb  in  4  CPU write byte strobes.
- cpu_mem_ready  out  1  ready returned to CPU.
- cpu_mem_rdata  out  32  read data returned to CPU.
- mem_valid  out  1  request valid to bram_controller.
- mem_addr  out  32  address to bram_controller.
- mem_wdata  out  32  write data to bram_controller.
- mem_wstrb  out  4  write strobes to bram_controller.
- mem_ready  in  1  ready from bram_controller.
- mem_rdata  in  32  read data from bram_controller.
- load_done  out  1  high while in RUN.
- load_error  out  1  high while in ERROR.

Behaviour:
- Reset (synchronous, active-high):
  - state=IDLE, word index=0, byte counter=0, length=0.
  - rx_ready=1, cpu_reset_n=0, mem_valid=0, cpu_mem_ready=0, load_done=0, load_error=0.
- States: IDLE, LEN0, LEN1, DATA, WRITE, RUN, ERROR.
- IDLE: accepted byte equal to MAGIC -> LEN0. Any other accepted byte is discarded.
- LEN0: accepted byte -> length[7:0]; go to LEN1.
- LEN1: accepted byte -> length[15:8].
  - If length==0 or length>MEM_WORDS -> ERROR.
  - Otherwise -> DATA.
- DATA: accepted bytes fill word bits [8k+7:8k] for k=0..3, first byte lowest. On the 4th byte -> WRITE.
- rx_ready: 1 in IDLE, LEN0, LEN1, DATA; 0 in WRITE, RUN, ERROR.
- WRITE:
  - Registered outputs: mem_valid=1, mem_addr=LOAD_BASE+{index,2'b00} (32-bit wrap), mem_wstrb=4'b1111, mem_wdata=assembled word.
  - mem_valid holds until the cycle mem_ready=1. It deasserts the next cycle and index increments.
  - Then: index==length-1 -> RUN, else -> DATA.
- RUN:
  - cpu_reset_n=1 from the first RUN cycle.
  - mem_valid/addr/wdata/wstrb come combinationally from cpu_mem_*.
  - cpu_mem_ready=mem_ready and cpu_mem_rdata=mem_rdata.
  - load_done=1.
- Outside RUN: cpu_mem_ready=0 and cpu_mem_rdata=0. CPU requests are ignored because the CPU is held in reset.
- ERROR:
  - cpu_reset_n=0, load_error=1.
  - Stays in ERROR until reset.
- Reset asserted mid-load or mid-WRITE: returns to IDLE next edge and drops mem_valid immediately. The partially written image is not erased.
- Loader-side mem_* outputs are zero when idle.

Optional Feature:
- Macro BOOT_LOADER_RELOAD_EN.
- When defined:
  - In RUN, rx_ready=1.
  - An accepted MAGIC byte drives cpu_reset_n=0 next cycle and moves to DRAIN.
  - DRAIN keeps the bus on the CPU side until cpu_mem_valid==0 or mem_ready==1 is seen, then goes to LEN0 with index cleared.
  - Non-MAGIC bytes in RUN are discarded.
- When undefined: RUN is terminal (rx_ready=0) and the DRAIN state does not exist.

Test Plan:
- Bytes A5 02 00 13 05 A0 00 6F 00 00 00 -> BRAM[0]=00A00513, BRAM[1]=0000006F. cpu_reset_n rises the cycle after the second mem_ready; load_done=1.
- Bytes 00 FF A5 01 00 78 56 34 12 -> the two leading bytes are dropped; one write with addr=0x0 and wdata=12345678.
- Header A5 00 00 -> load_error=1, cpu_reset_n stays 0, no mem_valid. Same for A5 01 01 (257 > MEM_WORDS).
- rx_valid held continuously during load -> rx_ready=0 throughout each WRITE; no byte is lost or duplicated; mem_valid is held through a 2-cycle mem_ready delay.
- Load addi/addi/add/sw(x0,x1,0x80)/jal image, run 100 cycles, read 0x80 -> 0000001E.
- With BOOT_LOADER_RELOAD_EN, send A5 during RUN mid-CPU-fetch -> cpu_reset_n=0 next cycle. The new 1-word image is written only after the outstanding CPU access completes.
